// File: rtl/pipe_split_arb_pkg.sv
// rtl/pipe_split_arb_pkg.sv - shared state encoding and widths for pipe_split_arbiter
package pipe_split_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int RUN_W = 4;
    localparam int CNT_W = 16;

    function automatic arb_state_t owner_state(input logic id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way winner selection with bounded hold for the last-served owner
module rr_pick2
    import pipe_split_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             i_valid0,
    input  logic             i_valid1,
    input  arb_state_t       i_state,
    input  logic [RUN_W-1:0] i_run,
    output logic             o_winner,
    output arb_state_t       o_next_state,
    output logic [RUN_W-1:0] o_next_run
);

    localparam logic [RUN_W-1:0] HOLD_L  = RUN_W'(HOLD_MAX);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    logic w_owner;
    logic w_owner_v;
    logic w_other_v;
    logic w_keep;

    assign w_owner   = (i_state == OWN1);
    assign w_owner_v = w_owner ? i_valid1 : i_valid0;
    assign w_other_v = w_owner ? i_valid0 : i_valid1;

    always_comb begin
        o_winner = 1'b0;
        if (i_state == IDLE) begin
            o_winner = !i_valid0;
        end else if (w_owner_v && (!w_other_v || (i_run < HOLD_L))) begin
            o_winner = w_owner;
        end else begin
            o_winner = !w_owner;
        end
    end

    assign w_keep       = (i_state != IDLE) && (o_winner == w_owner);
    assign o_next_state = owner_state(o_winner);
    // Run saturates at the hold limit while the owner streams alone.
    assign o_next_run   = w_keep ? ((i_run < HOLD_L) ? i_run + RUN_ONE : i_run) : RUN_ONE;

endmodule

// File: rtl/pipe_split_arbiter.sv
// rtl/pipe_split_arbiter.sv - two-requester arbiter feeding one registered split output word
// Optional grant statistics: PIPE_SPLIT_ARB_STATS_EN
module pipe_split_arbiter
    import pipe_split_arb_pkg::*;
#(
    parameter int A_W      = 8,
    parameter int B_W      = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [A_W+B_W-1:0] req0_data,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [A_W+B_W-1:0] req1_data,
    output logic               req1_ready,
    output logic [A_W-1:0]     sig_a,
    output logic [B_W-1:0]     sig_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               grant_id
`ifdef PIPE_SPLIT_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]   gnt_cnt0,
    output logic [CNT_W-1:0]   gnt_cnt1
`endif
);

    localparam int D_W = A_W + B_W;

    arb_state_t       r_state;
    logic [RUN_W-1:0] r_run;
    logic             r_out_valid;
    logic [D_W-1:0]   r_word;
    logic             r_grant_id;

    logic             w_free;
    logic             w_any;
    logic             w_xfer;
    logic             w_go_idle;
    logic             w_winner;
    arb_state_t       w_next_state;
    logic [RUN_W-1:0] w_next_run;

    assign w_free    = !r_out_valid || out_ready;
    assign w_any     = req0_valid || req1_valid;
    assign w_xfer    = !rst && w_free && w_any;
    assign w_go_idle = (r_state != IDLE) && !w_any && !r_out_valid;

    rr_pick2 #(
        .HOLD_MAX (HOLD_MAX)
    ) u_pick (
        .i_valid0     (req0_valid),
        .i_valid1     (req1_valid),
        .i_state      (r_state),
        .i_run        (r_run),
        .o_winner     (w_winner),
        .o_next_state (w_next_state),
        .o_next_run   (w_next_run)
    );

    assign req0_ready = w_xfer && !w_winner;
    assign req1_ready = w_xfer &&  w_winner;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_run       <= '0;
            r_out_valid <= 1'b0;
            r_word      <= '0;
            r_grant_id  <= 1'b0;
        end else if (w_xfer) begin
            r_word      <= w_winner ? req1_data : req0_data;
            r_grant_id  <= w_winner;
            r_out_valid <= 1'b1;
            r_state     <= w_next_state;
            r_run       <= w_next_run;
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            // Ownership is forgotten only once the pipe has fully drained.
            if (w_go_idle) begin
                r_state <= IDLE;
                r_run   <= '0;
            end
        end
    end

    assign sig_a     = r_word[D_W-1:B_W];
    assign sig_b     = r_word[B_W-1:0];
    assign out_valid = r_out_valid;
    assign grant_id  = r_grant_id;

`ifdef PIPE_SPLIT_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (req0_ready && (r_cnt0 != '1)) begin
                r_cnt0 <= r_cnt0 + CNT_ONE;
            end
            if (req1_ready && (r_cnt1 != '1)) begin
                r_cnt1 <= r_cnt1 + CNT_ONE;
            end
        end
    end

    assign gnt_cnt0 = r_cnt0;
    assign gnt_cnt1 = r_cnt1;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_split_arbiter.sv
// tb/tb_pipe_split_arbiter.sv - self-checking bench with a queue-level arbitration model
module tb_pipe_split_arbiter;

    localparam int HOLD_MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic [15:0] req0_data = 16'h0;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [15:0] req1_data = 16'h0;
    logic        req1_ready;
    logic [7:0]  sig_a;
    logic [7:0]  sig_b;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        grant_id;
`ifdef PIPE_SPLIT_ARB_STATS_EN
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;
`endif

    pipe_split_arbiter #(
        .A_W      (8),
        .B_W      (8),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sig_a      (sig_a),
        .sig_b      (sig_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .grant_id   (grant_id)
`ifdef PIPE_SPLIT_ARB_STATS_EN
        ,
        .gnt_cnt0   (gnt_cnt0),
        .gnt_cnt1   (gnt_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who was served last, how many times in a row, and the word in the output slot.
    int          m_owner = -1;
    int          m_run   = 0;
    bit          m_valid = 1'b0;
    logic [7:0]  m_a     = 8'h0;
    logic [7:0]  m_b     = 8'h0;
    bit          m_gid   = 1'b0;
    int          m_cnt0  = 0;
    int          m_cnt1  = 0;
    int          m_w;
    bit          m_any;
    bit          m_free;
    logic [15:0] m_word;
    int          gseq[$];

    always @(negedge clk) begin
        m_any  = req0_valid || req1_valid;
        m_free = !m_valid || out_ready;
        m_w    = -1;
        if (!rst && m_free && m_any) begin
            if (req0_valid && req1_valid) begin
                if (m_owner < 0)             m_w = 0;
                else if (m_run < HOLD_MAX)   m_w = m_owner;
                else                         m_w = 1 - m_owner;
            end else begin
                m_w = req0_valid ? 0 : 1;
            end
        end

        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("sig_a", 32'(sig_a), 32'(m_a));
            chk("sig_b", 32'(sig_b), 32'(m_b));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("req0_ready", 32'(req0_ready), 32'(m_w == 0));
            chk("req1_ready", 32'(req1_ready), 32'(m_w == 1));
`ifdef PIPE_SPLIT_ARB_STATS_EN
            chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
            chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
`endif
        end

        if (req0_ready)      gseq.push_back(0);
        else if (req1_ready) gseq.push_back(1);

        if (rst) begin
            m_owner = -1; m_run = 0; m_valid = 1'b0;
            m_a = 8'h0; m_b = 8'h0; m_gid = 1'b0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else if (m_w >= 0) begin
            m_run   = (m_w == m_owner) ? m_run + 1 : 1;
            m_owner = m_w;
            m_word  = (m_w == 0) ? req0_data : req1_data;
            m_a     = m_word[15:8];
            m_b     = m_word[7:0];
            m_gid   = (m_w == 1);
            m_valid = 1'b1;
            if (m_w == 0 && m_cnt0 < 65535) m_cnt0++;
            if (m_w == 1 && m_cnt1 < 65535) m_cnt1++;
        end else begin
            if (m_owner >= 0 && !m_any && !m_valid) begin
                m_owner = -1;
                m_run   = 0;
            end
            if (out_ready) m_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          exp_seq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    logic [7:0]  hold_a;
    logic [7:0]  hold_b;

    initial begin
        tick();
        chk_en = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        tick();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_word", {16'h0, sig_a, sig_b}, 32'd0);
            chk("idle_readies", {30'h0, req1_ready, req0_ready}, 32'd0);
        end

        req0_valid = 1'b1; req0_data = 16'hA55A; out_ready = 1'b1;
        #1;
        chk("single_ready0", 32'(req0_ready), 32'd1);
        chk("single_ready1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("single_sig_a", 32'(sig_a), 32'hA5);
        chk("single_sig_b", 32'(sig_b), 32'h5A);
        chk("single_gid", 32'(grant_id), 32'd0);
        chk("single_valid", 32'(out_valid), 32'd1);
        repeat (3) tick();

        gseq.delete();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req0_data = 16'h1000 + 16'(i);
            req1_data = 16'h2000 + 16'(i);
            tick();
        end
        chk("seq_len", 32'(gseq.size()), 32'd9);
        for (int i = 0; i < 9 && i < gseq.size(); i++) begin
            chk($sformatf("seq[%0d]", i), 32'(gseq[i]), 32'(exp_seq[i]));
        end

        out_ready = 1'b0;
        hold_a = sig_a; hold_b = sig_b;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", {30'h0, req1_ready, req0_ready}, 32'd0);
            tick();
            chk("stall_word", {16'h0, sig_a, sig_b}, {16'h0, hold_a, hold_b});
        end
        req0_data = 16'hBEEF;
        out_ready = 1'b1;
        #1;
        chk("resume_ready0", 32'(req0_ready), 32'd1);
        tick();
        chk("resume_word", {16'h0, sig_a, sig_b}, 32'hBEEF);
        chk("resume_valid", 32'(out_valid), 32'd1);

        req0_valid = 1'b0; req1_data = 16'hC3C3;
        #1;
        chk("switch_ready1", 32'(req1_ready), 32'd1);
        tick();
        chk("switch_gid", 32'(grant_id), 32'd1);

        for (int i = 0; i < 60; i++) begin
            req0_valid = (i % 3) != 0;
            req1_valid = (i % 5) < 3;
            out_ready  = (i % 4) != 3;
            if (i >= 40) begin
                req0_valid = (i % 7) < 2;
                req1_valid = (i % 6) == 4;
                out_ready  = (i % 9) != 0;
            end
            req0_data = 16'h3000 + 16'(i * 17);
            req1_data = 16'h4000 + 16'(i * 29);
            tick();
        end

        req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("midrst_ready", {30'h0, req1_ready, req0_ready}, 32'd0);
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        #1;
        chk("midrst_idle_tie", 32'(req0_ready), 32'd1);
        tick();
        chk("midrst_gid", 32'(grant_id), 32'd0);

`ifdef PIPE_SPLIT_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0; out_ready = 1'b1;
        repeat (70000) tick();
        chk("sat_cnt0", 32'(gnt_cnt0), 32'hFFFF);
        chk("sat_cnt1", 32'(gnt_cnt1), 32'h0);
`endif

        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
